// File: rtl/lfsr_generator.sv
// Fibonacci-style LFSR bit/byte generator.
// A run is armed from IDLE by latching a set of 8-bit tap fields and a seed.
// The register is then warmed up for 2*SIZE advances, and from then on it
// emits one bit per enabled cycle. Each group of eight bits is also
// delivered as a byte, first bit in the MSB.
module lfsr_generator #(
  parameter int NUM_OF_TAPS = 15,
  parameter int SIZE        = 32
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     ena,
  input  logic [NUM_OF_TAPS*8-1:0] taps,
  input  logic                     taps_valid,
  input  logic [SIZE-1:0]          seed,
  input  logic                     restart,
  output logic                     dout_bit,
  output logic                     bit_valid,
  output logic [7:0]               dout_byte,
  output logic                     byte_valid,
  output logic                     busy
);

  localparam int                 CNT_W     = $clog2(2*SIZE);
  localparam logic [CNT_W-1:0]   WARM_LAST = CNT_W'(2*SIZE-1);
  localparam logic [SIZE-1:0]    ONE_SEED  = {{(SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } state_t;

  state_t                   state;
  state_t                   nextState;
  logic [SIZE-1:0]          r;
  logic [SIZE-1:0]          rNext;
  logic                     fb;
  logic [NUM_OF_TAPS*8-1:0] tapsLatched;
  logic [CNT_W-1:0]         warmCnt;
  logic [2:0]               bitCnt;
  logic [6:0]               byteShift;
  logic [SIZE-1:0]          loadValue;

  // An all-zero seed would lock the register, so it is replaced by 1.
  assign loadValue = (seed == '0) ? ONE_SEED : seed;

  // Feedback: MSB XOR every in-range tap position, with each field matched on all 8 bits.
  always_comb begin
    fb = r[SIZE-1];
    for (int k = 0; k < NUM_OF_TAPS; k++) begin
      for (int t = 1; t < SIZE; t++) begin
        if (tapsLatched[k*8 +: 8] == 8'(t)) begin
          fb = fb ^ r[t-1];
        end
      end
    end
    rNext = {r[SIZE-2:0], fb};
  end

  // State register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: restart dominates, and nothing moves while ena is low.
  always_comb begin
    nextState = state;
    if (restart) begin
      nextState = IDLE;
    end else if (ena) begin
      case (state)
        IDLE:    if (taps_valid) nextState = WARMUP;
        WARMUP:  if (warmCnt == WARM_LAST) nextState = RUN;
        RUN:     nextState = RUN;
        default: nextState = IDLE;
      endcase
    end
  end

  // Output decode of the registered state, so no input reaches busy combinationally.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: loads the taps and seed, advances the register, and assembles bits and bytes.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r           <= '0;
      tapsLatched <= '0;
      warmCnt     <= '0;
      bitCnt      <= '0;
      byteShift   <= '0;
      dout_bit    <= 1'b0;
      bit_valid   <= 1'b0;
      dout_byte   <= '0;
      byte_valid  <= 1'b0;
    end else if (restart) begin
      r          <= '0;
      warmCnt    <= '0;
      bitCnt     <= '0;
      byteShift  <= '0;
      dout_bit   <= 1'b0;
      bit_valid  <= 1'b0;
      dout_byte  <= '0;
      byte_valid <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      if (ena) begin
        case (state)
          IDLE: begin
            if (taps_valid) begin
              tapsLatched <= taps;
              r           <= loadValue;
              warmCnt     <= '0;
            end
          end
          WARMUP: begin
            r       <= rNext;
            warmCnt <= warmCnt + 1'b1;
          end
          RUN: begin
            dout_bit  <= r[SIZE-1];
            bit_valid <= 1'b1;
            r         <= rNext;
            byteShift <= {byteShift[5:0], r[SIZE-1]};
            bitCnt    <= bitCnt + 1'b1;
            if (bitCnt == 3'd7) begin
              dout_byte  <= {byteShift, r[SIZE-1]};
              byte_valid <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/lfsr_generator.md
LFSR_GENERATOR -- requirements
Module: lfsr_generator

Interface
REQ-001 SHALL have parameter NUM_OF_TAPS, default 15, number of 8-bit tap fields accepted.
REQ-002 SHALL have parameter SIZE, default 32, shift-register length in bits (legal 9..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port res  input  1  reset; one clock; reset asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  global advance enable; 0 freezes all state.
REQ-006 SHALL have port taps  input  NUM_OF_TAPS*8  tap fields from the upstream tap selector; field k = taps[k*8+7:k*8].
REQ-007 SHALL have port taps_valid  input  1  upstream done flag; level-sensitive.
REQ-008 SHALL have port seed  input  SIZE  initial register contents.
REQ-009 SHALL have port restart  input  1  synchronous return to IDLE.
REQ-010 SHALL have port dout_bit  output  1  generated bit.
REQ-011 SHALL have port bit_valid  output  1  dout_bit valid this cycle.
REQ-012 SHALL have port dout_byte  output  8  assembled byte, first bit in MSB.
REQ-013 SHALL have port byte_valid  output  1  one-cycle pulse, dout_byte complete.
REQ-014 SHALL have port busy  output  1  high in WARMUP or RUN.

Function
REQ-015 SHALL implement states IDLE, WARMUP, RUN; one-hot or binary encoding free.
REQ-016 IDLE: on edge with ena=1 and taps_valid=1, SHALL latch all taps fields, load r<=seed (r<=1 if seed==0), clear warmup counter, go WARMUP.
REQ-017 Taps/seed SHALL be latched only in IDLE; changes on taps, seed, taps_valid outside IDLE SHALL be ignored.
REQ-018 Advance SHALL be: fb = r[SIZE-1] XOR (XOR over every latched field t with 1<=t<=SIZE-1 of r[t-1]); r <= {r[SIZE-2:0], fb}.
REQ-019 Fields equal to 0 or >= SIZE SHALL contribute nothing; duplicate fields SHALL each contribute (pairs cancel); all 8 bits of a field SHALL be compared.
REQ-020 WARMUP: each edge with ena=1 SHALL perform one advance and increment counter; after the 2*SIZE-th advance SHALL go RUN; no valid outputs in WARMUP.
REQ-021 RUN: each edge with ena=1 SHALL register dout_bit<=r[SIZE-1] (pre-advance value), set bit_valid=1, perform one advance, shift the bit into the byte assembler.
REQ-022 Latency: taps_valid sampled at edge N with ena held 1 -> bit_valid first high after edge N+2*SIZE+1.
REQ-023 Byte assembler SHALL collect 8 consecutive RUN bits MSB-first; after the 8th, dout_byte SHALL update and byte_valid SHALL pulse 1 cycle; bit count 3 bits, wraps 7->0.
REQ-024 ena=0 on an edge: no advance, counters/state hold, bit_valid=0, byte_valid=0, dout_bit/dout_byte hold.
REQ-025 restart=1 on an edge SHALL take priority over all else: state IDLE, bit_valid=0, byte_valid=0, byte counter 0, dout_bit/dout_byte 0, r cleared; latched taps may be overwritten by next load.
REQ-026 restart=1 with taps_valid=1 in same edge: restart wins; load occurs on a later edge.
REQ-027 busy SHALL be a registered decode of state (1 in WARMUP/RUN), no combinational path from inputs to any output.

Reset
REQ-028 res=0 SHALL immediately, independent of clk: state IDLE, r=0, latched taps=0, counters=0, all outputs 0.
REQ-029 Release of res SHALL take effect on the first clk edge with res=1; no load on that edge unless ena=1 and taps_valid=1.

Verification
REQ-030 SIZE=32, taps all 0, seed 0x00000001, ena=1, taps_valid pulse -> 64 warmup cycles, then bits 31x0 then 1 repeating; bytes 0x00,0x00,0x00,0x01 repeating, byte_valid every 8th RUN cycle.
REQ-031 Same as REQ-030 with seed 0 -> identical output stream (zero seed forced to 1).
REQ-032 Taps fields 0x25 and 0x20 (>=SIZE) and pair 0x05,0x05 -> identical to REQ-030 stream.
REQ-033 ena toggled 0 for 10 cycles mid-WARMUP and mid-byte in RUN -> stream identical to REQ-030 apart from gaps; bit_valid=0 during gaps.
REQ-034 res=0 asserted between edges during RUN -> outputs 0 at once; after release, new load reproduces REQ-030 from first bit.
REQ-035 restart=1 together with taps_valid=1 in RUN -> IDLE next edge, busy=0; load only when taps_valid seen with restart=0.
